gray_monitor: RTL and testbench
===============================

// Module: gray_monitor
// PURPOSE
//  Downstream consumer of the 4-bit Gray counter output (gray_out).
//  Registers the Gray stream, decodes it to binary, and checks that each
//  sample is exactly the successor of the previous one (mod 2^WIDTH).
//  Reports lock status, step errors and wrap events for LEDs/debug.
// PARAMETERS
//  WIDTH      4  Gray/binary word width
//  ERR_W      8  error counter width (saturating)
//  WRAP_W     8  wrap counter width (free-running, wraps)
//  LOCK_N     3  consecutive good steps needed to assert locked (1..15)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        synchronous, active-high
//  gray_in      in   WIDTH    Gray code from counter
//  gray_valid   in   1        gray_in is a new sample this cycle
//  bin_out      out  WIDTH    decoded binary of last accepted sample
//  bin_valid    out  1        1-cycle pulse: bin_out updated
//  step_err     out  1        1-cycle pulse: sequence violation
//  err_count    out  ERR_W    saturating count of step_err pulses
//  wrap_count   out  WRAP_W   count of 2^WIDTH-1 -> 0 transitions
//  locked       out  1        LOCK_N consecutive good steps seen
//  hamming_err  out  1        1-cycle pulse: raw Gray distance != 1
// BEHAVIOUR
//  - Reset (synchronous, active-high): every output 0, FSM -> SYNC,
//    reference and good-step counter cleared. Reset wins over gray_valid.
//  - Pipeline: stage 1 registers gray_in/gray_valid; stage 2 decodes
//    (b[W-1]=g[W-1], b[i]=b[i+1]^g[i]) and checks. gray_valid at cycle N ->
//    bin_valid/step_err/hamming_err at N+2. Back-to-back valids accepted
//    every cycle; gaps in gray_valid ignored (no timeout).
//  - FSM states: SYNC, CHECK.
//    SYNC : first valid sample loads reference ref=bin; bin_valid pulses;
//           no error check; -> CHECK.
//    CHECK: per valid sample with decoded value d:
//           d == ref+1 mod 2^WIDTH : good; good_cnt++ (saturates at LOCK_N);
//             locked=1 when good_cnt reaches LOCK_N; ref=d.
//             If ref==2^WIDTH-1 and d==0: wrap_count++ (mod 2^WRAP_W).
//           d == ref : repeat; no error, no count change, locked unchanged.
//           otherwise: step_err pulse; err_count++ (holds at 2^ERR_W-1);
//             good_cnt=0; locked=0; ref=d (resync in place, stay CHECK).
//  - bin_out updates on every accepted sample, including error samples.
//  - step_err and a good/wrap step are mutually exclusive per sample.
//  - Reset mid-stream: pipeline contents discarded; next valid sample is
//    treated as a SYNC sample (no error on it).
// CONFIGURATION
//  GRAY_MON_HAMMING_EN defined: stage 2 also compares raw Gray words of
//    consecutive accepted samples in CHECK; popcount(g^g_prev) != 1 and
//    g != g_prev -> hamming_err pulse (same cycle as step_err timing).
//  Not defined: hamming_err tied 0, raw-Gray history register omitted.
// TESTING
//  1 Reset 2 cycles, drive Gray 0..15,0..15 valid every cycle -> no
//    step_err, locked=1 after sample 4 (3rd good step), wrap_count=2 after 2nd 15->0, bin_out=0 at end.
//  2 Sequence 0,1,3,2 then inject 4'b0101 (bin 6) instead of 6 (bin 4) ->
//    one step_err 2 cycles later, err_count=1, locked=0, next 7 (Gray 0100) good.
//  3 Valid gaps: samples 1,2 with 5 idle cycles between, plus repeat of 2 ->
//    no step_err, bin_valid pulses only on valid samples.
//  4 ERR_W=2: inject 5 bad steps -> err_count stops at 3.
//  5 Assert reset mid-count at value 9, release, feed 12 -> no step_err,
//    locked=0, bin_out=12, wrap_count=0.
//  6 With GRAY_MON_HAMMING_EN: Gray 0000 -> 0011 -> hamming_err=1 and
//    step_err=1; without macro -> hamming_err stays 0.

Source files
------------

// File: rtl/gray_monitor.sv
// gray_monitor: two-stage checker for a Gray-coded counter stream.
// Stage 1 registers the raw sample; stage 2 decodes it to binary and checks
// that it is the successor of the previous accepted value.
// Optional feature macro: GRAY_MON_HAMMING_EN enables the raw Gray
// distance check (hamming_err); otherwise hamming_err is tied low.
module gray_monitor #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ERR_W  = 8,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned LOCK_N = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  gray_in,
    input  logic              gray_valid,
    output logic [WIDTH-1:0]  bin_out,
    output logic              bin_valid,
    output logic              step_err,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              locked,
    output logic              hamming_err
);

    typedef enum logic {SYNC, CHECK} state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_N);

    logic [WIDTH-1:0]  g_s1;
    logic              v_s1;
    logic [WIDTH-1:0]  dec;
    logic [WIDTH-1:0]  ref_inc;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  ref_q, ref_d;
    logic [3:0]        good_q, good_d;
    logic [WIDTH-1:0]  bin_d;
    logic              bv_d;
    logic              se_d;
    logic [ERR_W-1:0]  ec_d;
    logic [WRAP_W-1:0] wc_d;
    logic              lk_d;

    // Stage 1: capture the incoming sample and its qualifier.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_s1 <= '0;
            v_s1 <= 1'b0;
        end else begin
            g_s1 <= gray_in;
            v_s1 <= gray_valid;
        end
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        dec = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dec[i] = ^(g_s1 >> i);
        end
    end

    assign ref_inc = ref_q + 1'b1;

    // Stage 2 state register: FSM, reference, good-step count and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SYNC;
            ref_q      <= '0;
            good_q     <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            step_err   <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            locked     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_q      <= ref_d;
            good_q     <= good_d;
            bin_out    <= bin_d;
            bin_valid  <= bv_d;
            step_err   <= se_d;
            err_count  <= ec_d;
            wrap_count <= wc_d;
            locked     <= lk_d;
        end
    end

    // Stage 2 next-state: classify each accepted sample as sync, good, repeat or error.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        good_d  = good_q;
        bin_d   = bin_out;
        bv_d    = 1'b0;
        se_d    = 1'b0;
        ec_d    = err_count;
        wc_d    = wrap_count;
        lk_d    = locked;
        if (v_s1) begin
            bin_d = dec;
            bv_d  = 1'b1;
            unique case (state_q)
                SYNC: begin
                    ref_d   = dec;
                    state_d = CHECK;
                end
                CHECK: begin
                    if (dec == ref_inc) begin
                        if (good_q != LOCK_V) begin
                            good_d = good_q + 1'b1;
                        end
                        if (good_d == LOCK_V) begin
                            lk_d = 1'b1;
                        end
                        if ((ref_q == '1) && (dec == '0)) begin
                            wc_d = wrap_count + 1'b1;
                        end
                        ref_d = dec;
                    end else if (dec != ref_q) begin
                        se_d = 1'b1;
                        if (err_count != '1) begin
                            ec_d = err_count + 1'b1;
                        end
                        good_d = '0;
                        lk_d   = 1'b0;
                        ref_d  = dec;
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

`ifdef GRAY_MON_HAMMING_EN
    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] g_diff;

    assign g_diff = g_s1 ^ g_prev;

    // Raw Gray history: flag consecutive accepted samples that are neither equal nor one bit apart.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_prev      <= '0;
            hamming_err <= 1'b0;
        end else begin
            hamming_err <= 1'b0;
            if (v_s1) begin
                g_prev <= g_s1;
                if ((state_q == CHECK) && (g_diff != '0) && ($countones(g_diff) != 1)) begin
                    hamming_err <= 1'b1;
                end
            end
        end
    end
`else
    assign hamming_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: stimulus pushes hand-computed expected
// results; a negedge monitor pops one entry per bin_valid pulse and compares.
// A second instance with a 2-bit error counter checks saturation.
module tb_gray_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] gray_in = '0;
    logic       gray_valid = 1'b0;

    logic [3:0] bin_out;
    logic       bin_valid, step_err, locked, hamming_err;
    logic [7:0] err_count, wrap_count;

    logic [3:0] bin_out2;
    logic       bin_valid2, step_err2, locked2, hamming_err2;
    logic [1:0] err_count2;
    logic [7:0] wrap_count2;

    int tests = 0;
    int fails = 0;

`ifdef GRAY_MON_HAMMING_EN
    localparam bit HAM_ON = 1'b1;
`else
    localparam bit HAM_ON = 1'b0;
`endif

    // Gray codes of binary 0..15
    logic [3:0] GRAY [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    typedef struct {
        logic [3:0] bin;
        logic       se;
        logic [7:0] ec;
        logic [1:0] ec2;
        logic [7:0] wc;
        logic       lk;
        logic       he;
    } exp_t;

    exp_t sb[$];

    gray_monitor #(.WIDTH(4), .ERR_W(8), .WRAP_W(8), .LOCK_N(3)) dut (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_err(step_err),
        .err_count(err_count), .wrap_count(wrap_count), .locked(locked),
        .hamming_err(hamming_err)
    );

    gray_monitor #(.WIDTH(4), .ERR_W(2), .WRAP_W(8), .LOCK_N(3)) dut2 (
        .clk(clk), .reset(reset), .gray_in(gray_in), .gray_valid(gray_valid),
        .bin_out(bin_out2), .bin_valid(bin_valid2), .step_err(step_err2),
        .err_count(err_count2), .wrap_count(wrap_count2), .locked(locked2),
        .hamming_err(hamming_err2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int b, input bit se, input int ec, input int ec2,
                                input int wc, input bit lk, input bit he);
        exp_t e;
        e.bin = 4'(b);
        e.se  = se;
        e.ec  = 8'(ec);
        e.ec2 = 2'(ec2);
        e.wc  = 8'(wc);
        e.lk  = lk;
        e.he  = he;
        return e;
    endfunction

    // Monitor: every bin_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bin_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_bin_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("bin_out", bin_out, e.bin);
                chk("step_err", step_err, e.se);
                chk("err_count", err_count, e.ec);
                chk("err_count_w2", err_count2, e.ec2);
                chk("wrap_count", wrap_count, e.wc);
                chk("locked", locked, e.lk);
                chk("hamming_err", hamming_err, e.he);
            end
        end
    end

    task automatic send(input logic [3:0] g, input bit push, input exp_t e);
        gray_in    = g;
        gray_valid = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        gray_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bin_out", bin_out, 0);
        chk("rst_bin_valid", bin_valid, 0);
        chk("rst_step_err", step_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_err_count_w2", err_count2, 0);
        chk("rst_wrap_count", wrap_count, 0);
        chk("rst_locked", locked, 0);
        chk("rst_hamming_err", hamming_err, 0);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        idle(4);
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        exp_t e;
        e = mk(0, 0, 0, 0, 0, 0, 0);

        // 1: two full laps plus a final 0, back-to-back
        do_reset();
        for (int k = 0; k < 33; k++) begin
            send(GRAY[k % 16], 1,
                 mk(k % 16, 0, 0, 0, (k >= 16 ? 1 : 0) + (k >= 32 ? 1 : 0), k >= 3, 0));
        end
        drain("t1_drain");
        chk("t1_final_bin_out", bin_out, 0);

        // 2: bad step 0010 -> 0101 (bin 3 -> 6), then 0100 (bin 7) is good
        do_reset();
        send(4'b0000, 1, mk(0, 0, 0, 0, 0, 0, 0));
        send(4'b0001, 1, mk(1, 0, 0, 0, 0, 0, 0));
        send(4'b0011, 1, mk(2, 0, 0, 0, 0, 0, 0));
        send(4'b0010, 1, mk(3, 0, 0, 0, 0, 1, 0));
        send(4'b0101, 1, mk(6, 1, 1, 1, 0, 0, HAM_ON));
        send(4'b0100, 1, mk(7, 0, 1, 1, 0, 0, 0));
        drain("t2_drain");

        // 3: gaps between samples and a repeated sample
        do_reset();
        send(4'b0001, 1, mk(1, 0, 0, 0, 0, 0, 0));
        idle(5);
        send(4'b0011, 1, mk(2, 0, 0, 0, 0, 0, 0));
        idle(5);
        send(4'b0011, 1, mk(2, 0, 0, 0, 0, 0, 0));
        drain("t3_drain");

        // 4: five bad steps 0 -> 5 -> 10 -> 3 -> 12 -> 7; 2-bit counter saturates at 3
        do_reset();
        send(4'b0000, 1, mk(0, 0, 0, 0, 0, 0, 0));
        send(4'b0111, 1, mk(5, 1, 1, 1, 0, 0, HAM_ON));
        send(4'b1111, 1, mk(10, 1, 2, 2, 0, 0, 0));
        send(4'b0010, 1, mk(3, 1, 3, 3, 0, 0, HAM_ON));
        send(4'b1010, 1, mk(12, 1, 4, 3, 0, 0, 0));
        send(4'b0100, 1, mk(7, 1, 5, 3, 0, 0, HAM_ON));
        drain("t4_drain");

        // 5: reset while sample 9 is in flight, then 12 is a fresh sync sample
        do_reset();
        for (int k = 0; k < 9; k++) begin
            send(GRAY[k], 1, mk(k, 0, 0, 0, 0, k >= 3, 0));
        end
        send(GRAY[9], 0, e);
        do_reset();
        send(GRAY[12], 1, mk(12, 0, 0, 0, 0, 0, 0));
        send(GRAY[13], 1, mk(13, 0, 0, 0, 0, 0, 0));
        drain("t5_drain");

        // 6: 0000 -> 0011 is both a step error and a two-bit Gray jump
        do_reset();
        send(4'b0000, 1, mk(0, 0, 0, 0, 0, 0, 0));
        send(4'b0011, 1, mk(2, 1, 1, 1, 0, 0, HAM_ON));
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
